data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/rv_mem_pkg.sv | 39 +++
 rtl/dmem_lane_align.sv | 36 +++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types and helpers for the data memory responder
package rv_mem_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte enables for an access of the given size starting at lane 0.
  function automatic logic [7:0] size_byte_mask(input size_e size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input size_e size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte merge and load extract/extend for one 64-bit word
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  size_e            size,
  input  logic             is_unsigned,
  input  logic [2:0]       lane,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  old_word,
  output logic [XLEN-1:0]  new_word,
  output logic [XLEN-1:0]  load_data
);

  logic [7:0]      byte_en;
  logic [XLEN-1:0] bit_mask;
  logic [XLEN-1:0] wshift;
  logic [XLEN-1:0] rshift;

  always_comb begin
    byte_en = size_byte_mask(size) << lane;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_en[i]}};
    end
    wshift   = wdata << {lane, 3'b000};
    new_word = (old_word & ~bit_mask) | (wshift & bit_mask);

    rshift = old_word >> {lane, 3'b000};
    case (size)
      SZ_B:    load_data = is_unsigned ? {56'b0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
      SZ_H:    load_data = is_unsigned ? {48'b0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
      SZ_W:    load_data = is_unsigned ? {32'b0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
      default: load_data = rshift;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency 64-bit data memory with valid/ready request and response
module data_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  state_e state, state_next;
  logic [CW-1:0]   cnt;
  logic            lat_write;
  logic [XLEN-1:0] lat_addr;
  logic [2:0]      lat_funct3;
  logic [XLEN-1:0] lat_wdata;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            enter_resp;
  logic            eff_write;
  logic [XLEN-1:0] eff_addr;
  logic [2:0]      eff_funct3;
  logic [XLEN-1:0] eff_wdata;
  size_e           eff_size;
  logic [AW-1:0]   word_idx;
  logic            misaligned;
  logic            out_of_range;
  logic            acc_err;
  logic [XLEN-1:0] new_word;
  logic [XLEN-1:0] load_data;

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge itself, so the
  // datapath must look at the live request rather than the latch.
  assign enter_resp = (state == ST_IDLE && accept && LATENCY == 1) ||
                      (state == ST_WAIT && cnt == CW'(1));

  always_comb begin
    if (state == ST_IDLE) begin
      eff_write  = req_write;
      eff_addr   = req_addr;
      eff_funct3 = req_funct3;
      eff_wdata  = req_wdata;
    end else begin
      eff_write  = lat_write;
      eff_addr   = lat_addr;
      eff_funct3 = lat_funct3;
      eff_wdata  = lat_wdata;
    end
  end

  assign eff_size     = size_e'(eff_funct3[1:0]);
  assign word_idx     = eff_addr[3 +: AW];
  assign misaligned   = (eff_addr[2:0] & size_align_mask(eff_size)) != 3'b000;
  assign out_of_range = |eff_addr[XLEN-1:3+AW];
  assign acc_err      = misaligned || out_of_range;

  dmem_lane_align u_align (
    .size        (eff_size),
    .is_unsigned (eff_funct3[2] && (eff_size != SZ_D)),
    .lane        (eff_addr[2:0]),
    .wdata       (eff_wdata),
    .old_word    (mem[word_idx]),
    .new_word    (new_word),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == CW'(1)) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_write  <= req_write;
        lat_addr   <= req_addr;
        lat_funct3 <= req_funct3;
        lat_wdata  <= req_wdata;
        cnt        <= CW'(LATENCY - 1);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (enter_resp) begin
        rsp_rdata <= (acc_err || eff_write) ? '0 : load_data;
        rsp_err   <= acc_err;
      end
    end
  end

  // Array is deliberately not reset; rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && eff_write && !acc_err) begin
      mem[word_idx] <= new_word;
    end
  end

endmodule
